arm_irq_ack_ctrl: RTL
=====================

// Module: arm_irq_ack_ctrl
// PURPOSE
//  - ARM-side end of the peripheral interrupt vector: latches CAN A/B (U,S) and 1553 interrupt events into a pending register.
//  - Applies a mask and drives one level IRQ line to the ARM.
//  - ARM reads, masks and acknowledges (write-1-to-clear) over the 16-bit FPGA register bus.
//  - Sits between the peripheral interrupt sources and the ARM external-interrupt pin.
// PARAMETERS
//  N_SRC          5     number of interrupt sources (bit0 CAN_A_U .. bit4 BUS1553)
//  DATA_W         16    register bus data width
//  HOLDOFF_CYC    8     minimum IRQ deassert time in clk cycles (1..255)
//  MASK_RST       5'h00 reset value of MASK (1 = enabled)
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  src_irq    in   N_SRC   raw peripheral interrupt levels, asynchronous to clk
//  bus_addr   in   2       register select
//  bus_wr     in   1       write strobe, one cycle
//  bus_rd     in   1       read strobe, one cycle
//  bus_wdata  in   DATA_W  write data
//  bus_rdata  out  DATA_W  read data, registered
//  bus_rvalid out  1       high one cycle when bus_rdata is valid
//  arm_irq    out  1       active-high interrupt request to ARM
// BEHAVIOUR
//  - Reset: PENDING=0, MASK=MASK_RST, bus_rdata=0, bus_rvalid=0, arm_irq=0, FSM=IDLE, sync flops=0.
//  - Each src_irq bit passes through a 2-flop synchronizer. A rising edge of the synchronized bit sets PENDING[i].
//  - Source rise to PENDING set: 3 clk.
//  - Registers:
//      addr 0 STATUS: R = PENDING; W1C.
//      addr 1 MASK: RW.
//      addr 2 RAW: RO synchronized levels.
//      addr 3 VECTOR: see CONFIGURATION.
//  - Bits above N_SRC read 0 and ignore writes.
//  - Read latency: bus_rd at cycle n gives bus_rdata/bus_rvalid at n+1. bus_rdata holds its value until the next read.
//  - bus_wr and bus_rd in the same cycle: both are performed; the read returns the pre-write value.
//  - Same-cycle edge and W1C on one bit: the set wins; the bit stays 1.
//  - Writing MASK never alters PENDING. Masked sources still latch.
//  - active = |(PENDING & MASK).
//  - IRQ FSM:
//      IDLE: arm_irq=0; if active, go to ASSERT.
//      ASSERT: arm_irq=1; if !active, go to HOLDOFF and load cnt=HOLDOFF_CYC-1.
//      HOLDOFF: arm_irq=0; decrement cnt; when cnt==0, go to IDLE.
//  - arm_irq is registered, so it rises 1 clk after active first becomes 1 in IDLE.
//  - During HOLDOFF, newly active sources wait; IRQ is reasserted only after returning to IDLE. This guarantees the ARM sees a fresh edge.
//  - Reset mid-operation: everything returns to reset values immediately. Any edge in flight in the synchronizer is lost.
// CONFIGURATION
//  - Macro IRQ_VECTOR_EN:
//      Defined: reading VECTOR returns idx+1 of the lowest-index bit set in (PENDING & MASK), or 0 if none. The read also clears that PENDING bit in the same cycle as bus_rd (read-to-ack). A simultaneous new edge on that bit still wins.
//      Undefined: VECTOR reads 0 and has no side effect; the priority encoder is not built.
// STRUCTURE
//  - Package arm_irq_pkg holds: register address localparams (ADDR_STATUS=0, ADDR_MASK=1, ADDR_RAW=2, ADDR_VECTOR=3), the FSM state encoding (IDLE/ASSERT/HOLDOFF), and the source bit index constants.
//  - Sub-module irq_sync_edge: 2-flop synchronizer plus rising-edge pulse, instantiated N_SRC times.
// TESTING
//  - Reset release, MASK_RST=0: pulse src_irq[4] -> STATUS reads 5'h10, arm_irq stays 0.
//  - MASK=5'h01; raise src_irq[0] -> arm_irq=1 4 clk after the edge. W1C 5'h01 -> arm_irq=0 next clk. It stays 0 for exactly 8 clk even if src 0 re-pends.
//  - STATUS=5'h03; W1C 5'h01 on the same clk as a new src_irq[0] edge reaches the edge detector -> STATUS stays 5'h03.
//  - IRQ_VECTOR_EN, MASK=5'h1F, PENDING=5'h14 -> VECTOR reads 3, then 5, then 0. STATUS is 0 after the third read; arm_irq falls.
//  - Without IRQ_VECTOR_EN: VECTOR read -> 0, and PENDING is unchanged.
//  - Assert rst_n low while in ASSERT with PENDING=5'h1F -> arm_irq=0 and STATUS=0 immediately. MASK returns to MASK_RST.

Source files
------------

// File: rtl/arm_irq_pkg.sv
// Shared definitions for the ARM interrupt acknowledge controller:
// register map, IRQ state encoding and source bit positions.
package arm_irq_pkg;

  // Register map on the 16-bit FPGA register bus
  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_RAW    = 2'd2;
  localparam logic [1:0] ADDR_VECTOR = 2'd3;

  // Interrupt source bit positions
  localparam int SRC_CAN_A_U = 0;
  localparam int SRC_CAN_A_S = 1;
  localparam int SRC_CAN_B_U = 2;
  localparam int SRC_CAN_B_S = 3;
  localparam int SRC_BUS1553 = 4;

  // IRQ line state machine
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for one asynchronous interrupt level, plus a
// third flop holding the previous synchronized level so a one-cycle
// rising-edge pulse can be produced.
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  output logic level,
  output logic rise
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Metastability stages followed by the edge-detect history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= src;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign level = sync_r;
  assign rise  = sync_r & ~prev_r;

endmodule

// File: rtl/arm_irq_ack_ctrl.sv
// ARM-side end of the peripheral interrupt vector. Latches CAN A/B and
// 1553 interrupt edges into PENDING, masks them, and drives one level
// IRQ to the ARM with a guaranteed minimum deassert time so every
// reassertion is a fresh edge.
// Optional feature: define IRQ_VECTOR_EN to build the VECTOR register
// (lowest pending+enabled source index + 1, with read-to-acknowledge).
module arm_irq_ack_ctrl
  import arm_irq_pkg::*;
#(
  parameter int                N_SRC       = 5,
  parameter int                DATA_W      = 16,
  parameter int                HOLDOFF_CYC = 8,
  parameter logic [N_SRC-1:0]  MASK_RST    = 5'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  src_irq,
  input  logic [1:0]        bus_addr,
  input  logic              bus_wr,
  input  logic              bus_rd,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_rvalid,
  output logic              arm_irq
);

  // HOLDOFF lasts HOLDOFF_CYC-1 cycles; together with the mandatory IDLE
  // cycle the line is low for HOLDOFF_CYC clocks before it can rise again.
  localparam logic [7:0] CNT_LOAD = 8'(HOLDOFF_CYC - 1);

  logic [N_SRC-1:0]  raw_s;
  logic [N_SRC-1:0]  rise_s;
  logic [N_SRC-1:0]  pending_r;
  logic [N_SRC-1:0]  mask_r;
  logic [N_SRC-1:0]  w1c_s;
  logic [N_SRC-1:0]  ack_s;
  logic [DATA_W-1:0] vec_code_s;
  logic [DATA_W-1:0] rd_data_s;
  logic              active_s;
  irq_state_e        state_r;
  irq_state_e        state_s;
  logic [7:0]        cnt_r;
  logic [7:0]        cnt_s;
  logic              unused_wdata_s;

  assign unused_wdata_s = ^bus_wdata[DATA_W-1:N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .src   (src_irq[i]),
      .level (raw_s[i]),
      .rise  (rise_s[i])
    );
  end

`ifdef IRQ_VECTOR_EN
  function automatic logic [DATA_W-1:0] vec_code(input logic [N_SRC-1:0] v);
    logic [DATA_W-1:0] code;
    code = {DATA_W{1'b0}};
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) code = DATA_W'(i + 1);
      else      code = code;
    end
    return code;
  endfunction

  function automatic logic [N_SRC-1:0] lowest_onehot(input logic [N_SRC-1:0] v);
    return v & (~v + {{(N_SRC-1){1'b0}}, 1'b1});
  endfunction

  assign vec_code_s = vec_code(pending_r & mask_r);
  assign ack_s      = (bus_rd && (bus_addr == ADDR_VECTOR)) ?
                      lowest_onehot(pending_r & mask_r) : {N_SRC{1'b0}};
`else
  assign vec_code_s = {DATA_W{1'b0}};
  assign ack_s      = {N_SRC{1'b0}};
`endif

  assign w1c_s    = (bus_wr && (bus_addr == ADDR_STATUS)) ? bus_wdata[N_SRC-1:0] : {N_SRC{1'b0}};
  assign active_s = |(pending_r & mask_r);

  // Pending latch (new edge beats any clear) and mask register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {N_SRC{1'b0}};
      mask_r    <= MASK_RST;
    end else begin
      pending_r <= (pending_r & ~(w1c_s | ack_s)) | rise_s;
      if (bus_wr && (bus_addr == ADDR_MASK)) mask_r <= bus_wdata[N_SRC-1:0];
    end
  end

  // Read mux, evaluated on pre-write register contents
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    case (bus_addr)
      ADDR_STATUS: rd_data_s = {{(DATA_W-N_SRC){1'b0}}, pending_r};
      ADDR_MASK:   rd_data_s = {{(DATA_W-N_SRC){1'b0}}, mask_r};
      ADDR_RAW:    rd_data_s = {{(DATA_W-N_SRC){1'b0}}, raw_s};
      ADDR_VECTOR: rd_data_s = vec_code_s;
      default:     rd_data_s = {DATA_W{1'b0}};
    endcase
  end

  // Registered read port; data holds until the next read strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rdata  <= {DATA_W{1'b0}};
      bus_rvalid <= 1'b0;
    end else begin
      bus_rvalid <= bus_rd;
      if (bus_rd) bus_rdata <= rd_data_s;
    end
  end

  // IRQ line next-state and holdoff counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (active_s) state_s = ST_ASSERT;
        else          state_s = ST_IDLE;
      end
      ST_ASSERT: begin
        if (!active_s) begin
          state_s = ST_HOLDOFF;
          cnt_s   = CNT_LOAD;
        end else begin
          state_s = ST_ASSERT;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_r <= 8'd1) begin
          state_s = ST_IDLE;
          cnt_s   = 8'd0;
        end else begin
          state_s = ST_HOLDOFF;
          cnt_s   = cnt_r - 8'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // IRQ state register; arm_irq is registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      arm_irq <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      arm_irq <= (state_s == ST_ASSERT);
    end
  end

endmodule
